// File: rtl/kypd_pkg.sv
// Shared types and constants for the 4x4 Pmod keypad scanner.
// Key map and column drive are indexed as col*4 + row and col respectively.
package kypd_pkg;

    typedef enum logic {SCAN, EVAL} state_e;

    typedef enum logic [1:0] {NONE, SINGLE, GHOST} scan_class_e;

    localparam logic [3:0][3:0] COL_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,   // col3
        4'hE, 4'h9, 4'h6, 4'h3,   // col2
        4'hF, 4'h8, 4'h5, 4'h2,   // col1
        4'h0, 4'h7, 4'h4, 4'h1    // col0
    };

endpackage

// File: rtl/kypd_if.sv
// Key-event handshake between the keypad scanner and the port logic.
interface kypd_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (output key_code, key_valid, key_held, overrun, input  key_ack);
    modport slave  (input  key_code, key_valid, key_held, overrun, output key_ack);
endinterface

// File: rtl/kypd_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
module kypd_row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_async,
    output logic [3:0] row_sync
);
    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            meta     <= row_async;
            row_sync <= meta;
        end
    end
endmodule

// File: rtl/kypd_scanner.sv
// Active column scanner for the 4x4 keypad: debounce, ghost rejection, valid/ack events.
// Optional auto-repeat of a held key is enabled by defining KYPD_AUTOREPEAT_EN.
module kypd_scanner
    import kypd_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       OSC_100MHz,
    input  logic       RST,
    output logic [3:0] KYPD_COL,
    input  logic [3:0] KYPD_ROW,
    kypd_if.master     kp
);
    localparam int         DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB      = 4'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1)
    begin : g_bad_param
        $error("kypd_scanner: parameter out of range");
    end

    logic [3:0]       row_sync;
    state_e           state;
    logic [1:0]       col;
    logic [DIV_W-1:0] div_cnt;
    logic [15:0]      image;
    scan_class_e      prev_cls;
    logic [3:0]       prev_key;
    logic [3:0]       deb_cnt;

    kypd_row_sync u_row_sync (
        .clk      (OSC_100MHz),
        .rst_n    (RST),
        .row_async(KYPD_ROW),
        .row_sync (row_sync)
    );

    // Classify the completed scan image and work out debounce outcome.
    logic [4:0]  hit_cnt;
    logic [3:0]  hit_idx;
    scan_class_e cls;
    logic [3:0]  cand;
    logic        match, in_eval, press_acc, rel_acc, rep_emit, emit;
    logic [3:0]  deb_next;

    always_comb begin
        hit_cnt = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (image[i]) begin
                hit_cnt = hit_cnt + 5'd1;
                hit_idx = 4'(i);
            end
        end
        cls      = (hit_cnt == 5'd0) ? NONE : (hit_cnt == 5'd1) ? SINGLE : GHOST;
        cand     = KEY_MAP[hit_idx];
        match    = (cls == prev_cls) && (cls != SINGLE || cand == prev_key);
        deb_next = !match ? 4'd1 : (deb_cnt == DEB) ? deb_cnt : deb_cnt + 4'd1;
        in_eval  = (state == EVAL);
        press_acc = in_eval && cls == SINGLE && deb_next == DEB && !kp.key_held;
        rel_acc   = in_eval && cls == NONE   && deb_next == DEB;
        emit      = press_acc || rep_emit;
    end

`ifdef KYPD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0] rep_cnt;
    logic [3:0]       held_key;
    logic             same_key;

    assign same_key = kp.key_held && cls == SINGLE && cand == held_key;
    assign rep_emit = in_eval && same_key && rep_cnt == REP_W'(REPEAT_SCANS - 1);

    always_ff @(posedge OSC_100MHz or negedge RST) begin
        if (!RST) begin
            rep_cnt  <= '0;
            held_key <= '0;
        end else if (in_eval) begin
            if (press_acc) begin
                held_key <= cand;
                rep_cnt  <= '0;
            end else if (rep_emit || !same_key) begin
                rep_cnt  <= '0;
            end else begin
                rep_cnt  <= rep_cnt + 1'b1;
            end
        end
    end
`else
    assign rep_emit = 1'b0;
`endif

    always_ff @(posedge OSC_100MHz or negedge RST) begin
        if (!RST) begin
            state        <= SCAN;
            col          <= 2'd0;
            KYPD_COL     <= COL_DRIVE[0];
            div_cnt      <= '0;
            image        <= '0;
            prev_cls     <= NONE;
            prev_key     <= '0;
            deb_cnt      <= '0;
            kp.key_code  <= '0;
            kp.key_valid <= 1'b0;
            kp.key_held  <= 1'b0;
            kp.overrun   <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt                  <= '0;
                        image[{col, 2'b00} +: 4] <= ~row_sync;
                        if (col == 2'd3) begin
                            state <= EVAL;
                        end else begin
                            col      <= col + 2'd1;
                            KYPD_COL <= COL_DRIVE[col + 2'd1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    state    <= SCAN;
                    col      <= 2'd0;
                    KYPD_COL <= COL_DRIVE[0];
                    // A ghost scan is invisible to the debouncer.
                    if (cls != GHOST) begin
                        deb_cnt  <= deb_next;
                        prev_cls <= cls;
                        prev_key <= cand;
                    end
                    if (press_acc)    kp.key_held <= 1'b1;
                    else if (rel_acc) kp.key_held <= 1'b0;
                end
                default: state <= SCAN;
            endcase

            // Ack is taken first so a same-cycle event loads instead of overrunning.
            if (kp.key_ack && kp.key_valid) begin
                kp.key_valid <= 1'b0;
                kp.overrun   <= 1'b0;
            end
            if (emit) begin
                if (!kp.key_valid || kp.key_ack) begin
                    kp.key_code  <= cand;
                    kp.key_valid <= 1'b1;
                end else begin
                    kp.overrun   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_kypd_scanner.sv
// Directed bench for kypd_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=2 (scan period 33 cycles).
// The repeat scenario checks auto-repeat when KYPD_AUTOREPEAT_EN is defined, single-shot otherwise.
module tb_kypd_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] pressed = '0;
    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    logic kv_q = 1'b0;

    kypd_if kp();

    kypd_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(3)) dut (
        .OSC_100MHz(clk),
        .RST       (rst_n),
        .KYPD_COL  (col),
        .KYPD_ROW  (row),
        .kp        (kp)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (kp.key_valid && !kv_q) ev_cnt++;
        kv_q = kp.key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        kp.key_ack = 1'b0;
        pressed = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ev_cnt = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        kp.key_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rst_col: got %b want 1110", col); end
        checks++; if (kp.key_code !== 4'h0) begin errors++; $display("FAIL rst_code: got %h want 0", kp.key_code); end
        checks++; if (kp.key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", kp.key_valid); end
        checks++; if (kp.key_held !== 1'b0) begin errors++; $display("FAIL rst_held: got %b want 0", kp.key_held); end
        checks++; if (kp.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", kp.overrun); end
        rst_n = 1'b1;
        cycles(7);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL scan_c0: got %b want 1110", col); end
        cycles(1);
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL scan_c1: got %b want 1101", col); end
        cycles(8);
        checks++; if (col !== 4'b1011) begin errors++; $display("FAIL scan_c2: got %b want 1011", col); end
        cycles(8);
        checks++; if (col !== 4'b0111) begin errors++; $display("FAIL scan_c3: got %b want 0111", col); end
        cycles(8);
        checks++; if (col !== 4'b0111) begin errors++; $display("FAIL scan_eval: got %b want 0111", col); end
        cycles(1);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL scan_wrap: got %b want 1110", col); end
    endtask

    task automatic test_single_press;
        do_reset();
        pressed[9] = 1'b1;                       // key 6: col2 row1
        cycles(65);
        checks++; if (kp.key_valid !== 1'b0) begin errors++; $display("FAIL press_early: got %b want 0", kp.key_valid); end
        cycles(1);
        checks++; if (kp.key_valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b want 1", kp.key_valid); end
        checks++; if (kp.key_code !== 4'h6) begin errors++; $display("FAIL press_code: got %h want 6", kp.key_code); end
        checks++; if (kp.key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", kp.key_held); end
        cycles(33);
        checks++; if (ev_cnt !== 1) begin errors++; $display("FAIL press_once: got %0d events want 1", ev_cnt); end
        @(negedge clk) kp.key_ack = 1'b1;
        @(negedge clk) kp.key_ack = 1'b0;
        checks++; if (kp.key_valid !== 1'b0) begin errors++; $display("FAIL press_ack: got %b want 0", kp.key_valid); end
        pressed = '0;
        cycles(32);
        checks++; if (kp.key_held !== 1'b1) begin errors++; $display("FAIL release_early: got %b want 1", kp.key_held); end
        cycles(33);
        checks++; if (kp.key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b want 0", kp.key_held); end
        checks++; if (ev_cnt !== 1) begin errors++; $display("FAIL release_events: got %0d want 1", ev_cnt); end
    endtask

    task automatic test_bounce;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            pressed[5] = (i % 2 == 0);           // key 5: col1 row1
            cycles(5);
        end
        pressed[5] = 1'b1;
        cycles(66);
        checks++; if (kp.key_valid !== 1'b0) begin errors++; $display("FAIL bounce_quiet: got %b want 0", kp.key_valid); end
        checks++; if (ev_cnt !== 0) begin errors++; $display("FAIL bounce_events: got %0d want 0", ev_cnt); end
        cycles(1);
        checks++; if (kp.key_valid !== 1'b1) begin errors++; $display("FAIL bounce_valid: got %b want 1", kp.key_valid); end
        checks++; if (kp.key_code !== 4'h5) begin errors++; $display("FAIL bounce_code: got %h want 5", kp.key_code); end
        cycles(66);
        checks++; if (ev_cnt !== 1) begin errors++; $display("FAIL bounce_once: got %0d want 1", ev_cnt); end
    endtask

    task automatic test_ghost;
        do_reset();
        pressed[0] = 1'b1;                       // key 1
        pressed[4] = 1'b1;                       // key 2
        cycles(4 * 33 + 2);
        checks++; if (ev_cnt !== 0) begin errors++; $display("FAIL ghost_events: got %0d want 0", ev_cnt); end
        checks++; if (kp.key_valid !== 1'b0) begin errors++; $display("FAIL ghost_valid: got %b want 0", kp.key_valid); end
        checks++; if (kp.key_held !== 1'b0) begin errors++; $display("FAIL ghost_held: got %b want 0", kp.key_held); end
    endtask

    task automatic test_overrun;
        do_reset();
        pressed = 16'h0100;                      // key 3
        cycles(66);
        checks++; if (kp.key_code !== 4'h3) begin errors++; $display("FAIL ovr_first: got %h want 3", kp.key_code); end
        pressed = '0;
        cycles(66);
        checks++; if (kp.key_held !== 1'b0) begin errors++; $display("FAIL ovr_release: got %b want 0", kp.key_held); end
        pressed = 16'h0400;                      // key 9
        cycles(65);
        checks++; if (kp.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", kp.overrun); end
        cycles(1);
        checks++; if (kp.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", kp.overrun); end
        checks++; if (kp.key_code !== 4'h3) begin errors++; $display("FAIL ovr_code: got %h want 3", kp.key_code); end
        checks++; if (kp.key_held !== 1'b1) begin errors++; $display("FAIL ovr_held: got %b want 1", kp.key_held); end
        @(negedge clk) kp.key_ack = 1'b1;
        @(negedge clk) kp.key_ack = 1'b0;
        checks++; if (kp.key_valid !== 1'b0) begin errors++; $display("FAIL ack_valid: got %b want 0", kp.key_valid); end
        checks++; if (kp.overrun !== 1'b0) begin errors++; $display("FAIL ack_overrun: got %b want 0", kp.overrun); end
        pressed = '0;
        cycles(65);
        pressed = 16'h0100;                      // key 3 again, left pending
        cycles(66);
        checks++; if (kp.key_code !== 4'h3 || kp.key_valid !== 1'b1) begin errors++;
            $display("FAIL pend_load: got %h/%b want 3/1", kp.key_code, kp.key_valid); end
        pressed = '0;
        cycles(66);
        pressed = 16'h0800;                      // key E
        cycles(65);
        @(negedge clk) kp.key_ack = 1'b1;        // lands on the accept edge
        @(negedge clk) kp.key_ack = 1'b0;
        checks++; if (kp.key_valid !== 1'b1) begin errors++; $display("FAIL coll_valid: got %b want 1", kp.key_valid); end
        checks++; if (kp.key_code !== 4'hE) begin errors++; $display("FAIL coll_code: got %h want e", kp.key_code); end
        checks++; if (kp.overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun: got %b want 0", kp.overrun); end
        cycles(10);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL midrst_col: got %b want 1110", col); end
        checks++; if (kp.key_valid !== 1'b0 || kp.key_held !== 1'b0 || kp.key_code !== 4'h0) begin errors++;
            $display("FAIL midrst_out: got v%b h%b c%h want v0 h0 c0", kp.key_valid, kp.key_held, kp.key_code); end
    endtask

    task automatic test_repeat;
        int n_ev;
        int t_ev [8];
        logic [3:0] c_ev [8];
        do_reset();
        n_ev = 0;
        pressed = 16'h1000;                      // key A
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (kp.key_valid && !kp.key_ack) begin
                if (n_ev < 8) begin t_ev[n_ev] = i; c_ev[n_ev] = kp.key_code; end
                n_ev++;
            end
            kp.key_ack = kp.key_valid;
        end
        kp.key_ack = 1'b0;
`ifdef KYPD_AUTOREPEAT_EN
        checks++; if (n_ev !== 4) begin errors++; $display("FAIL rep_count: got %0d want 4", n_ev); end
`else
        checks++; if (n_ev !== 1) begin errors++; $display("FAIL rep_count: got %0d want 1", n_ev); end
`endif
        checks++; if (n_ev > 0 && t_ev[0] !== 66) begin errors++; $display("FAIL rep_first: got %0d want 66", t_ev[0]); end
        for (int k = 0; k < n_ev && k < 8; k++) begin
            checks++; if (c_ev[k] !== 4'hA) begin errors++; $display("FAIL rep_code%0d: got %h want a", k, c_ev[k]); end
            if (k > 0) begin
                checks++; if (t_ev[k] - t_ev[k-1] !== 99) begin errors++;
                    $display("FAIL rep_gap%0d: got %0d want 99", k, t_ev[k] - t_ev[k-1]); end
            end
        end
        checks++; if (kp.key_held !== 1'b1) begin errors++; $display("FAIL rep_held: got %b want 1", kp.key_held); end
    endtask

    initial begin
        kp.key_ack = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_ghost();
        test_overrun();
        test_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
